// File: rtl/gm_curve_mc.sv
// -----------------------------------------------------------------------------
// gm_curve_mc -- multi-channel piecewise-linear gamma / tone-curve engine.
//
// Every channel owns a knot table of NSEG+1 entries (NSEG = 2^SEG_BITS uniform
// segments over the input range). Host writes land in a shadow copy; a
// requested shadow->active copy is performed for all channels at once on the
// next frame-start pulse. The curve enable is also sampled at frame start, so
// both stay constant for the whole frame.
//
// Optional build macro: GM_CURVE_BLEND_EN
//   Defined   : adds gm_str[4:0] (0..16, values above 16 act as 16), sampled
//               at frame start; an extra stage blends the curve output with
//               the bypass value. Latency is 4 cycles.
//   Undefined : no gm_str port, latency is 3 cycles.
//
// Ports:
//   pclk, prst     pixel clock, synchronous active-high reset
//   px_i/px_vld_i  packed input pixels (channel c at [c*DATI_SZ +: DATI_SZ])
//   frm_str        one-cycle frame-start pulse
//   gm_en          curve enable (0 = bypass), sampled at frm_str
//   gm_str         blend strength (GM_CURVE_BLEND_EN builds only)
//   tbl_we/tbl_ch/tbl_addr/tbl_wdat   shadow knot write
//   tbl_upd        request shadow->active copy at the next frm_str
//   tbl_upd_pend   copy request pending
//   px_o/px_vld_o  packed output pixels and valid
//
// Stream handshake: valid-only. px_vld_i qualifies px_i for exactly one
// cycle; there is no ready and the pipeline never stalls. px_vld_o marks px_o
// valid for exactly one cycle, a fixed number of cycles later; bubbles pass
// through and px_o holds its last value while px_vld_o is low.
// -----------------------------------------------------------------------------
module gm_curve_mc #(
    parameter int  CH_NUM   = 3,
    parameter int  DATI_SZ  = 10,
    parameter int  DATO_SZ  = 10,
    parameter int  SEG_BITS = 4,
    localparam int CHW      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                      pclk,
    input  logic                      prst,
    input  logic [CH_NUM*DATI_SZ-1:0] px_i,
    input  logic                      px_vld_i,
    input  logic                      frm_str,
    input  logic                      gm_en,
`ifdef GM_CURVE_BLEND_EN
    input  logic [4:0]                gm_str,
`endif
    input  logic                      tbl_we,
    input  logic [CHW-1:0]            tbl_ch,
    input  logic [SEG_BITS:0]         tbl_addr,
    input  logic [DATO_SZ-1:0]        tbl_wdat,
    input  logic                      tbl_upd,
    output logic                      tbl_upd_pend,
    output logic [CH_NUM*DATO_SZ-1:0] px_o,
    output logic                      px_vld_o
);

    localparam int NSEG = 1 << SEG_BITS;
    localparam int DXW  = DATI_SZ - SEG_BITS;   // bits of offset inside a segment
    localparam int DYW  = DATO_SZ + 1;          // signed knot delta
    localparam int PW   = DATO_SZ + DXW + 2;    // signed product with headroom
    localparam logic [SEG_BITS:0]    ADDR_MAX = (SEG_BITS+1)'(NSEG);
    localparam logic [CHW:0]         CH_LIM   = (CHW+1)'(CH_NUM);
    localparam logic signed [PW-1:0] RND      = PW'(1 << (DXW - 1));
`ifdef GM_CURVE_BLEND_EN
    localparam int BW = DATO_SZ + 6;
`endif

    // Identity knot: y[k] = min((k << DATO_SZ) >> SEG_BITS, 2^DATO_SZ - 1).
    function automatic logic [DATO_SZ-1:0] ident_knot(input int k);
        longint v;
        v = (longint'(k) << DATO_SZ) >> SEG_BITS;
        if (v > longint'((1 << DATO_SZ) - 1))
            v = longint'((1 << DATO_SZ) - 1);
        return v[DATO_SZ-1:0];
    endfunction

    // ------------------------------------------------------------------ tables
    logic [DATO_SZ-1:0] r_shadow [CH_NUM][NSEG+1];
    logic [DATO_SZ-1:0] r_act    [CH_NUM][NSEG+1];
    logic               r_upd_pend;
    logic               r_gm_en_act;
`ifdef GM_CURVE_BLEND_EN
    logic [4:0]         r_str_act;
`endif
    logic               w_swap;
    logic               w_wr_ok;

    // A request arriving together with frame start swaps on that same edge.
    assign w_swap  = frm_str & (r_upd_pend | tbl_upd);
    assign w_wr_ok = tbl_we && (tbl_addr <= ADDR_MAX) && ({1'b0, tbl_ch} < CH_LIM);

    always_ff @(posedge pclk) begin
        if (prst) begin
            for (int c = 0; c < CH_NUM; c++) begin
                for (int k = 0; k <= NSEG; k++) begin
                    r_shadow[c][k] <= ident_knot(k);
                    r_act[c][k]    <= ident_knot(k);
                end
            end
            r_upd_pend  <= 1'b0;
            r_gm_en_act <= 1'b0;
`ifdef GM_CURVE_BLEND_EN
            r_str_act   <= 5'd0;
`endif
        end else begin
            // Non-blocking copy: a write on the swap edge reaches shadow only,
            // active receives the pre-write shadow contents.
            if (w_swap)
                r_act <= r_shadow;
            if (w_wr_ok)
                r_shadow[tbl_ch][tbl_addr] <= tbl_wdat;
            if (w_swap)
                r_upd_pend <= 1'b0;
            else if (tbl_upd)
                r_upd_pend <= 1'b1;
            if (frm_str) begin
                r_gm_en_act <= gm_en;
`ifdef GM_CURVE_BLEND_EN
                r_str_act   <= (gm_str > 5'd16) ? 5'd16 : gm_str;
`endif
            end
        end
    end

    assign tbl_upd_pend = r_upd_pend;

    // ---------------------------------------------------------------- pipeline
    logic                      r_s1_vld, r_s2_vld, r_out_vld;
    logic                      r_s1_en, r_s2_en;
    logic [DATO_SZ-1:0]        r_s1_y0   [CH_NUM];
    logic signed [DYW-1:0]     r_s1_dy   [CH_NUM];
    logic [DXW-1:0]            r_s1_dx   [CH_NUM];
    logic [DATO_SZ-1:0]        r_s1_lin  [CH_NUM];
    logic [DATO_SZ-1:0]        r_s2_y0   [CH_NUM];
    logic signed [PW-1:0]      r_s2_prod [CH_NUM];
    logic [DATO_SZ-1:0]        r_s2_lin  [CH_NUM];
    logic [DATO_SZ-1:0]        r_out     [CH_NUM];
`ifdef GM_CURVE_BLEND_EN
    logic                      r_s3_vld, r_s3_en;
    logic [4:0]                r_s1_str, r_s2_str, r_s3_str;
    logic [DATO_SZ-1:0]        r_s3_crv  [CH_NUM];
    logic [DATO_SZ-1:0]        r_s3_lin  [CH_NUM];
    logic [DATO_SZ-1:0]        w_bl      [CH_NUM];
`endif

    logic [DATO_SZ-1:0]        w_y0   [CH_NUM];
    logic signed [DYW-1:0]     w_dy   [CH_NUM];
    logic [DXW-1:0]            w_dx   [CH_NUM];
    logic [DATO_SZ-1:0]        w_lin  [CH_NUM];
    logic signed [PW-1:0]      w_prod [CH_NUM];
    logic [DATO_SZ-1:0]        w_crv  [CH_NUM];

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [DATI_SZ-1:0]   w_x;
        logic [SEG_BITS:0]    w_k0;
        logic [SEG_BITS:0]    w_k1;
        logic [DATO_SZ-1:0]   w_y1;
        logic signed [PW-1:0] w_dx_s;
        logic signed [PW-1:0] w_dy_s;
        logic signed [PW-1:0] w_sh;
        logic signed [PW-1:0] w_sum;
        logic                 w_unused_hi;

        // S1 inputs: segment index, offset, the two bounding knots.
        assign w_x     = px_i[c*DATI_SZ +: DATI_SZ];
        assign w_k0    = {1'b0, w_x[DATI_SZ-1 -: SEG_BITS]};
        assign w_k1    = w_k0 + (SEG_BITS+1)'(1);
        assign w_dx[c] = w_x[DXW-1:0];
        assign w_y0[c] = r_act[c][w_k0];
        assign w_y1    = r_act[c][w_k1];
        assign w_dy[c] = $signed({1'b0, w_y1}) - $signed({1'b0, w_y0[c]});

        if (DATI_SZ >= DATO_SZ) begin : g_msb
            assign w_lin[c] = w_x[DATI_SZ-1 -: DATO_SZ];
        end else begin : g_shl
            assign w_lin[c] = {w_x, {(DATO_SZ-DATI_SZ){1'b0}}};
        end

        // S2: offset times signed delta, plus half a segment for rounding.
        assign w_dx_s    = $signed({{(PW-DXW){1'b0}}, r_s1_dx[c]});
        assign w_dy_s    = $signed({{(PW-DYW){r_s1_dy[c][DYW-1]}}, r_s1_dy[c]});
        assign w_prod[c] = w_dx_s * w_dy_s + RND;

        // S3: arithmetic shift floors toward -inf; the result always lies
        // between the two knots, so dropping the upper bits is lossless.
        assign w_sh        = r_s2_prod[c] >>> DXW;
        assign w_sum       = $signed({{(PW-DATO_SZ){1'b0}}, r_s2_y0[c]}) + w_sh;
        assign w_crv[c]    = w_sum[DATO_SZ-1:0];
        assign w_unused_hi = ^w_sum[PW-1:DATO_SZ];

`ifdef GM_CURVE_BLEND_EN
        logic [BW-1:0] w_mix;
        logic          w_unused_mix;
        assign w_mix = BW'(r_s3_crv[c]) * BW'(r_s3_str)
                     + BW'(r_s3_lin[c]) * BW'(5'd16 - r_s3_str) + BW'(8);
        assign w_bl[c]      = w_mix[DATO_SZ+3:4];
        assign w_unused_mix = ^{w_mix[BW-1:DATO_SZ+4], w_mix[3:0]};
`endif
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_out_vld <= 1'b0;
            r_s1_en   <= 1'b0;
            r_s2_en   <= 1'b0;
            for (int c = 0; c < CH_NUM; c++) begin
                r_s1_y0[c]   <= '0;
                r_s1_dy[c]   <= '0;
                r_s1_dx[c]   <= '0;
                r_s1_lin[c]  <= '0;
                r_s2_y0[c]   <= '0;
                r_s2_prod[c] <= '0;
                r_s2_lin[c]  <= '0;
                r_out[c]     <= '0;
`ifdef GM_CURVE_BLEND_EN
                r_s3_crv[c]  <= '0;
                r_s3_lin[c]  <= '0;
`endif
            end
`ifdef GM_CURVE_BLEND_EN
            r_s3_vld <= 1'b0;
            r_s3_en  <= 1'b0;
            r_s1_str <= 5'd0;
            r_s2_str <= 5'd0;
            r_s3_str <= 5'd0;
`endif
        end else begin
            r_s1_vld <= px_vld_i;
            r_s2_vld <= r_s1_vld;
            // Settings travel with the pixel, so a pixel coincident with
            // frm_str still sees the previous frame's table and enable.
            if (px_vld_i) begin
                r_s1_en <= r_gm_en_act;
`ifdef GM_CURVE_BLEND_EN
                r_s1_str <= r_str_act;
`endif
                for (int c = 0; c < CH_NUM; c++) begin
                    r_s1_y0[c]  <= w_y0[c];
                    r_s1_dy[c]  <= w_dy[c];
                    r_s1_dx[c]  <= w_dx[c];
                    r_s1_lin[c] <= w_lin[c];
                end
            end
            if (r_s1_vld) begin
                r_s2_en <= r_s1_en;
`ifdef GM_CURVE_BLEND_EN
                r_s2_str <= r_s1_str;
`endif
                for (int c = 0; c < CH_NUM; c++) begin
                    r_s2_y0[c]   <= r_s1_y0[c];
                    r_s2_prod[c] <= w_prod[c];
                    r_s2_lin[c]  <= r_s1_lin[c];
                end
            end
`ifdef GM_CURVE_BLEND_EN
            r_s3_vld  <= r_s2_vld;
            r_out_vld <= r_s3_vld;
            if (r_s2_vld) begin
                r_s3_en  <= r_s2_en;
                r_s3_str <= r_s2_str;
                for (int c = 0; c < CH_NUM; c++) begin
                    r_s3_crv[c] <= w_crv[c];
                    r_s3_lin[c] <= r_s2_lin[c];
                end
            end
            if (r_s3_vld) begin
                for (int c = 0; c < CH_NUM; c++)
                    r_out[c] <= r_s3_en ? w_bl[c] : r_s3_lin[c];
            end
`else
            r_out_vld <= r_s2_vld;
            if (r_s2_vld) begin
                for (int c = 0; c < CH_NUM; c++)
                    r_out[c] <= r_s2_en ? w_crv[c] : r_s2_lin[c];
            end
`endif
        end
    end

    always_comb begin
        px_o = '0;
        for (int c = 0; c < CH_NUM; c++)
            px_o[c*DATO_SZ +: DATO_SZ] = r_out[c];
    end

    assign px_vld_o = r_out_vld;

endmodule

// File: tb/tb_gm_curve_mc.sv
// Testbench for gm_curve_mc: directed scenarios followed by randomized traffic,
// all checked against a table-level reference model through a scoreboard.
module tb_gm_curve_mc;
  localparam int CH_NUM   = 3;
  localparam int DATI_SZ  = 10;
  localparam int DATO_SZ  = 10;
  localparam int SEG_BITS = 4;
  localparam int CHW      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int NSEG     = 1 << SEG_BITS;
  localparam int SEGW     = 1 << (DATI_SZ - SEG_BITS);
  localparam int OMAX     = (1 << DATO_SZ) - 1;
  localparam int IMAX     = (1 << DATI_SZ) - 1;
  localparam int PXW_I    = CH_NUM * DATI_SZ;
  localparam int PXW_O    = CH_NUM * DATO_SZ;
`ifdef GM_CURVE_BLEND_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  // ---------------------------------------------------------- clock / reset
  logic pclk = 1'b0;
  initial forever #5 pclk = ~pclk;

  int edge_cnt = 0;
  always @(posedge pclk) edge_cnt <= edge_cnt + 1;

  logic               prst;
  logic [PXW_I-1:0]   px_i;
  logic               px_vld_i;
  logic               frm_str;
  logic               gm_en;
  logic               tbl_we;
  logic [CHW-1:0]     tbl_ch;
  logic [SEG_BITS:0]  tbl_addr;
  logic [DATO_SZ-1:0] tbl_wdat;
  logic               tbl_upd;
  logic               tbl_upd_pend;
  logic [PXW_O-1:0]   px_o;
  logic               px_vld_o;
`ifdef GM_CURVE_BLEND_EN
  logic [4:0]         gm_str;
  int                 str_m;
`endif

  gm_curve_mc #(
    .CH_NUM(CH_NUM), .DATI_SZ(DATI_SZ), .DATO_SZ(DATO_SZ), .SEG_BITS(SEG_BITS)
  ) dut (
    .pclk(pclk), .prst(prst), .px_i(px_i), .px_vld_i(px_vld_i),
    .frm_str(frm_str), .gm_en(gm_en),
`ifdef GM_CURVE_BLEND_EN
    .gm_str(gm_str),
`endif
    .tbl_we(tbl_we), .tbl_ch(tbl_ch), .tbl_addr(tbl_addr), .tbl_wdat(tbl_wdat),
    .tbl_upd(tbl_upd), .tbl_upd_pend(tbl_upd_pend),
    .px_o(px_o), .px_vld_o(px_vld_o)
  );

  // ------------------------------------------------------- reference model
  int shadow_m [CH_NUM][NSEG+1];
  int act_m    [CH_NUM][NSEG+1];
  bit pend_m;
  bit en_m;

  logic [PXW_O-1:0] exp_q[$];
  int               exp_t_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic int ident(input int k);
    int v;
    v = (k << DATO_SZ) >> SEG_BITS;
    return (v > OMAX) ? OMAX : v;
  endfunction

  function automatic int floor_div(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  function automatic int lin_of(input int x);
    if (DATI_SZ >= DATO_SZ) return x >> (DATI_SZ - DATO_SZ);
    return x << (DATO_SZ - DATI_SZ);
  endfunction

  // Straight-line interpolation between the two knots bracketing x.
  function automatic int curve_of(input int c, input int x);
    int k, dx, y0, y1;
    k  = x / SEGW;
    dx = x % SEGW;
    y0 = act_m[c][k];
    y1 = act_m[c][k+1];
    return y0 + floor_div(dx * (y1 - y0) + SEGW / 2, SEGW);
  endfunction

  function automatic logic [PXW_O-1:0] ref_px(input logic [PXW_I-1:0] px);
    logic [PXW_O-1:0] r;
    int x, v;
    r = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      x = int'(px[c*DATI_SZ +: DATI_SZ]);
      if (!en_m) v = lin_of(x);
      else begin
`ifdef GM_CURVE_BLEND_EN
        v = (curve_of(c, x) * str_m + lin_of(x) * (16 - str_m) + 8) / 16;
`else
        v = curve_of(c, x);
`endif
      end
      r[c*DATO_SZ +: DATO_SZ] = DATO_SZ'(v);
    end
    return r;
  endfunction

  function automatic logic [PXW_I-1:0] rep(input int v);
    logic [PXW_I-1:0] p;
    for (int c = 0; c < CH_NUM; c++) p[c*DATI_SZ +: DATI_SZ] = DATI_SZ'(v);
    return p;
  endfunction

  function automatic logic [PXW_I-1:0] rand_px();
    logic [PXW_I-1:0] p;
    for (int c = 0; c < CH_NUM; c++)
      p[c*DATI_SZ +: DATI_SZ] = DATI_SZ'($urandom_range(0, IMAX));
    return p;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ----------------------------------------------------------- driver tasks
  // One clock of stimulus; the model absorbs the same inputs at the same edge.
  task automatic step(input bit vld, input logic [PXW_I-1:0] px, input bit frm,
                      input bit upd, input bit we, input int ch, input int addr,
                      input int wdat);
    px_vld_i = vld;
    px_i     = px;
    frm_str  = frm;
    tbl_upd  = upd;
    tbl_we   = we;
    tbl_ch   = CHW'(ch);
    tbl_addr = (SEG_BITS+1)'(addr);
    tbl_wdat = DATO_SZ'(wdat);
    if (vld) begin
      exp_q.push_back(ref_px(px));
      exp_t_q.push_back(edge_cnt + LAT);
    end
    if (frm && (pend_m || upd)) begin
      act_m  = shadow_m;
      pend_m = 1'b0;
    end else if (upd) begin
      pend_m = 1'b1;
    end
    if (frm) begin
      en_m = gm_en;
`ifdef GM_CURVE_BLEND_EN
      str_m = (gm_str > 5'd16) ? 16 : int'(gm_str);
`endif
    end
    if (we && addr <= NSEG && ch < CH_NUM) shadow_m[ch][addr] = wdat;
    @(posedge pclk);
    #1;
    check("upd_pend", longint'(tbl_upd_pend), longint'(pend_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix(input int v);
    step(1, rep(v), 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int ch, input int addr, input int wdat);
    step(0, '0, 0, 0, 1, ch, addr, wdat);
  endtask

  task automatic do_reset(input int n);
    prst = 1'b1; px_vld_i = 1'b0; frm_str = 1'b0; tbl_we = 1'b0; tbl_upd = 1'b0;
    repeat (n) @(posedge pclk);
    #1;
    exp_q.delete();
    exp_t_q.delete();
    for (int c = 0; c < CH_NUM; c++)
      for (int k = 0; k <= NSEG; k++) begin
        shadow_m[c][k] = ident(k);
        act_m[c][k]    = ident(k);
      end
    pend_m = 1'b0;
    en_m   = 1'b0;
    check("rst_vld", longint'(px_vld_o), 0);
    check("rst_px", longint'(px_o), 0);
    check("rst_pend", longint'(tbl_upd_pend), 0);
    prst = 1'b0;
  endtask

  // ------------------------------------------------------------- scoreboard
  always @(negedge pclk) begin
    logic [PXW_O-1:0] e;
    int t;
    if (px_vld_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_valid: got px_o 0x%0h with nothing expected (t=%0t)", px_o, $time);
      end else begin
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check("px_o", longint'(px_o), longint'(e));
        check("latency", longint'(edge_cnt), longint'(t));
      end
    end else if (exp_t_q.size() > 0 && exp_t_q[0] <= edge_cnt) begin
      e = exp_q.pop_front();
      t = exp_t_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_valid: got no output by edge %0d, required 0x%0h at edge %0d", edge_cnt, e, t);
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    prst = 1'b1; px_i = '0; px_vld_i = 1'b0; frm_str = 1'b0; gm_en = 1'b0;
    tbl_we = 1'b0; tbl_ch = '0; tbl_addr = '0; tbl_wdat = '0; tbl_upd = 1'b0;
`ifdef GM_CURVE_BLEND_EN
    gm_str = 5'd16;
`endif
    do_reset(2);

    // Identity curve: 500 -> 500, 1023 -> 1022.
    gm_en = 1'b1;
    step(0, '0, 1, 0, 0, 0, 0, 0);
    pix(500);
    pix(1023);
    idle(LAT + 1);

    // Descending segment on channel 1 only.
    wr(1, 3, 300);
    wr(1, 4, 100);
    step(0, '0, 0, 1, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0, 0, 0);
    pix(224);
    idle(LAT + 1);

    // Pending update without frame start, out-of-range writes ignored.
    wr(0, 3, 50);
    wr(0, 4, 256);
    wr(3, 3, 0);
    wr(2, NSEG + 3, 7);
    step(0, '0, 0, 1, 0, 0, 0, 0);
    pix(200);
    idle(2);
    check("pend_held", longint'(tbl_upd_pend), 1);
    step(1, rep(200), 1, 0, 0, 0, 0, 0);
    check("pend_clear", longint'(tbl_upd_pend), 0);
    pix(200);
    idle(LAT + 1);

    // Bypass frame; toggling gm_en mid-frame must not matter.
    gm_en = 1'b0;
    step(0, '0, 1, 0, 0, 0, 0, 0);
    pix(777);
    gm_en = 1'b1;
    pix(777);
    pix(300);
    idle(LAT + 1);

    // Alternating valid pattern.
    gm_en = 1'b1;
    step(0, '0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(i % 2 == 0, rand_px(), 0, 0, 0, 0, 0, 0);
    idle(LAT + 1);

    // Randomized traffic: writes, updates, frame starts, bubbles.
    for (int i = 0; i < 1500; i++) begin
      gm_en = ($urandom_range(0, 3) != 0);
`ifdef GM_CURVE_BLEND_EN
      gm_str = 5'($urandom_range(0, 20));
`endif
      step($urandom_range(0, 3) != 0, rand_px(), $urandom_range(0, 39) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3), $urandom_range(0, NSEG + 3),
           $urandom_range(0, OMAX));
    end

    // Reset with pixels in flight and an update pending.
    step(0, '0, 0, 1, 0, 0, 0, 0);
    pix(100);
    pix(600);
    pix(900);
    do_reset(1);
    gm_en = 1'b1;
`ifdef GM_CURVE_BLEND_EN
    gm_str = 5'd16;
`endif
    step(0, '0, 1, 0, 0, 0, 0, 0);
    pix(224);
    idle(LAT + 2);

    check("drain", longint'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
